wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Shares one Wishbone slave port between two bus masters, the instruction-side
//  (m1) and data-side (m0) wishbone bus interface units of the CPU.
//  Grants the bus per cycle-transaction (cyc held), muxes the owner onto the slave
//  and routes ack/data back. A watchdog ends a hung access with a one-cycle err.
// PARAMETERS
//  RR_MODE        0   0 = fixed priority (m0 wins); 1 = round-robin (the master not granted last wins)
//  TIMEOUT_CYCLES 255 Cycles of stb without ack before err is raised; 0 disables the watchdog
//  TMO_W          8   Watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  mX_cyc_i   in   1   master X (X=0,1) cycle request
//  mX_stb_i   in   1   master X strobe
//  mX_we_i    in   1   master X write enable
//  mX_sel_i   in   4   master X byte selects
//  mX_adr_i   in   32  master X address
//  mX_dat_i   in   32  master X write data
//  mX_dat_o   out  32  read data to master X
//  mX_ack_o   out  1   ack to master X
//  mX_err_o   out  1   watchdog error to master X
//  s_cyc_o, s_stb_o, s_we_o  out  1   slave control
//  s_sel_o    out  4   slave byte selects
//  s_adr_o    out  32  slave address
//  s_dat_o    out  32  slave write data
//  s_dat_i    in   32  slave read data
//  s_ack_i    in   1   slave ack
//  gnt_o      out  2   one-hot current owner ({m1,m0}); 2'b00 when idle
// BEHAVIOUR
//  - Reset: state IDLE, gnt_o=0, last-grant=m1 (so round-robin first favours m0), watchdog=0; all
//    s_* outputs, mX_ack_o, mX_err_o and mX_dat_o are 0.
//  - States: IDLE, OWN0, OWN1 (registered). gnt_o decodes state.
//  - Arbitration runs in IDLE, and in OWNx on any cycle where the owner's cyc_i=0; the
//    result is registered, so a grant takes effect the cycle after the request is seen
//    (1-cycle latency). No requester -> IDLE.
//  - Both request the same cycle: RR_MODE=0 -> m0; RR_MODE=1 -> master other than last-grant.
//    last-grant updates on every entry into OWNx.
//  - Handoff: owner drops cyc while the other requests -> direct OWNx->OWNy, no idle cycle.
//  - Ownership is held while the owner's cyc_i=1 regardless of the other request (no preemption).
//  - In OWNx: s_cyc/stb/we/sel/adr/dat = mX inputs combinationally; mX_ack_o=s_ack_i,
//    mX_dat_o=s_dat_i. Non-owner: ack/err/dat_o = 0. IDLE: all s_* = 0.
//  - Watchdog: counts cycles in OWNx with s_stb_o=1 and s_ack_i=0; cleared on ack, on
//    owner stb=0 and on state change. When count == TIMEOUT_CYCLES-1 with still no ack:
//    mX_err_o=1 for exactly that cycle, s_cyc_o/s_stb_o forced 0 that cycle, counter cleared;
//    ownership kept until the owner drops cyc. Ack arriving in the err cycle wins (ack, no err).
//  - TIMEOUT_CYCLES=0: counter held at 0, err never asserted.
//  - rst mid-transaction: next cycle IDLE, slave cyc/stb drop immediately, no ack/err delivered.
//  - s_ack_i while IDLE is ignored (not routed to any master).
// TESTING
//  - m0 single read, slave acks after 2 cycles with 32'hDEADBEEF -> gnt_o=01 one cycle after
//    cyc, m0_ack_o=1 with m0_dat_o=32'hDEADBEEF, m1_ack_o stays 0.
//  - RR_MODE=0, m0 and m1 raise cyc together, 3 back-to-back -> m0 served every time, m1 waits
//    until m0 cyc=0 for one cycle; RR_MODE=1 same stimulus -> grants alternate m0,m1,m0.
//  - m1 owns, m0 requests mid-access -> no preemption; m1 drops cyc -> gnt_o goes 10->01 on
//    the next edge with no idle cycle.
//  - TIMEOUT_CYCLES=4, slave never acks -> m0_err_o single pulse on the 4th stb cycle, s_stb_o=0
//    that cycle; TIMEOUT_CYCLES=0 -> no err after 1000 cycles.
//  - Ack arrives on exactly the timeout cycle -> ack delivered, err stays 0.
//  - rst asserted while OWN1 with stb high -> next cycle gnt_o=00, s_cyc_o=0, all acks/errs 0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: grants one slave port per cyc-held transaction,
// routes ack/data back to the owner and ends hung accesses with a one-cycle err.
module wb_bus_arbiter #(
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 1: m1 was granted most recently
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic        owned;
  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic        stall;
  logic        tmo;
  logic        gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    case (state_q)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_sel = m1_sel_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    owned   = (state_q != IDLE);
    // A late ack suppresses the timeout, so the stall term already excludes it.
    stall   = TMO_EN && owned && own_stb && !s_ack_i;
    tmo     = stall && (cnt_q == TMO_LAST);

    state_d = state_q;
    if (!owned || !own_cyc) begin
      case ({m1_cyc_i, m0_cyc_i})
        2'b11:   state_d = (RR_MODE != 0 && !last_q) ? OWN1 : OWN0;
        2'b01:   state_d = OWN0;
        2'b10:   state_d = OWN1;
        default: state_d = IDLE;
      endcase
    end

    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == OWN0) last_d = 1'b0;
      if (state_d == OWN1) last_d = 1'b1;
    end

    cnt_d = '0;
    if (stall && !tmo && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  // Outputs are forced quiet while rst is high so a reset cuts the slave off at once.
  always_comb begin
    gate     = !rst;
    gnt_o    = {state_q == OWN1, state_q == OWN0};
    s_cyc_o  = gate && own_cyc && !tmo;
    s_stb_o  = gate && own_stb && !tmo;
    s_we_o   = gate && own_we;
    s_sel_o  = gate ? own_sel : '0;
    s_adr_o  = gate ? own_adr : '0;
    s_dat_o  = gate ? own_dat : '0;
    m0_ack_o = gate && (state_q == OWN0) && s_ack_i;
    m1_ack_o = gate && (state_q == OWN1) && s_ack_i;
    m0_err_o = gate && (state_q == OWN0) && tmo;
    m1_err_o = gate && (state_q == OWN1) && tmo;
    m0_dat_o = (gate && state_q == OWN0) ? s_dat_i : '0;
    m1_dat_o = (gate && state_q == OWN1) ? s_dat_i : '0;
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: three instances (fixed/RR with timeout 4, fixed with no
// watchdog) share master stimulus; each has its own slave and a transaction-level model.
module tb_wb_bus_arbiter;

  logic clk;
  logic rst;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic        ack [3];
  logic [31:0] sdat[3];

  logic [31:0] o_m0dat[3], o_m1dat[3], o_sadr[3], o_sdat[3];
  logic        o_m0ack[3], o_m1ack[3], o_m0err[3], o_m1err[3];
  logic        o_scyc[3], o_sstb[3], o_swe[3];
  logic [3:0]  o_ssel[3];
  logic [1:0]  o_gnt[3];

  int n_chk = 0;
  int n_err = 0;

  int own[3];
  int lst[3];
  int cnt[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_bus_arbiter #(
      .RR_MODE       ((g == 1) ? 1 : 0),
      .TIMEOUT_CYCLES((g == 2) ? 0 : 4),
      .TMO_W         (8)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .m0_cyc_i(cyc[0]),
      .m0_stb_i(stb[0]),
      .m0_we_i (we[0]),
      .m0_sel_i(sel[0]),
      .m0_adr_i(adr[0]),
      .m0_dat_i(wdat[0]),
      .m0_dat_o(o_m0dat[g]),
      .m0_ack_o(o_m0ack[g]),
      .m0_err_o(o_m0err[g]),
      .m1_cyc_i(cyc[1]),
      .m1_stb_i(stb[1]),
      .m1_we_i (we[1]),
      .m1_sel_i(sel[1]),
      .m1_adr_i(adr[1]),
      .m1_dat_i(wdat[1]),
      .m1_dat_o(o_m1dat[g]),
      .m1_ack_o(o_m1ack[g]),
      .m1_err_o(o_m1err[g]),
      .s_cyc_o (o_scyc[g]),
      .s_stb_o (o_sstb[g]),
      .s_we_o  (o_swe[g]),
      .s_sel_o (o_ssel[g]),
      .s_adr_o (o_sadr[g]),
      .s_dat_o (o_sdat[g]),
      .s_dat_i (sdat[g]),
      .s_ack_i (ack[g]),
      .gnt_o   (o_gnt[g])
    );
  end

  function automatic int tmo_of(int i);
    return (i == 2) ? 0 : 4;
  endfunction

  function automatic bit rr_of(int i);
    return (i == 1);
  endfunction

  // A stalled strobe on its final allowed cycle, with no ack arriving, is a timeout.
  function automatic bit timed_out(int i);
    int o;
    o = own[i];
    if (o < 0 || tmo_of(i) == 0) return 1'b0;
    return stb[o] && !ack[i] && (cnt[i] == tmo_of(i) - 1);
  endfunction

  function automatic logic [140:0] exp_vec(int i);
    int o;
    bit to;
    logic [1:0] g;
    o = own[i];
    g = (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
    if (rst || o < 0) return {g, 139'b0};
    to = timed_out(i);
    return {g, cyc[o] & ~to, stb[o] & ~to, we[o], sel[o], adr[o], wdat[o],
            (o == 0) & ack[i], (o == 1) & ack[i], (o == 0) & to, (o == 1) & to,
            (o == 0) ? sdat[i] : 32'h0, (o == 1) ? sdat[i] : 32'h0};
  endfunction

  function automatic logic [140:0] act_vec(int i);
    return {o_gnt[i], o_scyc[i], o_sstb[i], o_swe[i], o_ssel[i], o_sadr[i], o_sdat[i],
            o_m0ack[i], o_m1ack[i], o_m0err[i], o_m1err[i], o_m0dat[i], o_m1dat[i]};
  endfunction

  task automatic chk(input string nm, input logic [140:0] a, input logic [140:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  // Sample away from the rising edge and compare every instance against the model.
  task automatic settle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("model_i%0d", i), act_vec(i), exp_vec(i));
  endtask

  task automatic adv();
    int nxt;
    bit to;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        own[i] = -1;
        lst[i] = 1;
        cnt[i] = 0;
      end else begin
        to  = timed_out(i);
        nxt = own[i];
        if (own[i] < 0 || !cyc[own[i]]) begin
          if (cyc[0] && cyc[1]) nxt = rr_of(i) ? 1 - lst[i] : 0;
          else if (cyc[0])      nxt = 0;
          else if (cyc[1])      nxt = 1;
          else                  nxt = -1;
        end
        if (own[i] >= 0 && nxt == own[i] && tmo_of(i) != 0 && stb[own[i]] && !ack[i] && !to)
          cnt[i] = cnt[i] + 1;
        else
          cnt[i] = 0;
        if (nxt >= 0 && nxt != own[i]) lst[i] = nxt;
        own[i] = nxt;
      end
    end
    #1;
  endtask

  task automatic set_all_ack(input logic a, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      ack[i]  = a;
      sdat[i] = d;
    end
  endtask

  typedef struct {
    bit r, c0, s0, c1, s1, a;
    logic [31:0] d;
    logic [1:0]  g;
    bit k0, k1, e0, sc, ss;
    logic [31:0] q0;
  } vec_t;

  vec_t tbl[27];

  initial begin
    int errs0, errs2;
    logic [1:0] rr_exp[3];

    // inputs: rst c0 s0 c1 s1 ack dat | expected on instance 0: gnt ack0 ack1 err0 scyc sstb dat0
    tbl[0]  = '{1,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,32'h0};
    tbl[1]  = '{0,1,1,0,0,0,32'h0,        2'b00,0,0,0,0,0,32'h0};
    tbl[2]  = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[3]  = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[4]  = '{0,1,1,0,0,1,32'hDEADBEEF, 2'b01,1,0,0,1,1,32'hDEADBEEF};
    tbl[5]  = '{0,0,0,0,0,0,32'h0,        2'b01,0,0,0,0,0,32'h0};
    tbl[6]  = '{0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,32'h0};
    tbl[7]  = '{0,0,0,1,1,0,32'h0,        2'b00,0,0,0,0,0,32'h0};
    tbl[8]  = '{0,1,1,1,1,0,32'h0,        2'b10,0,0,0,1,1,32'h0};
    tbl[9]  = '{0,1,1,1,1,1,32'h12345678, 2'b10,0,1,0,1,1,32'h0};
    tbl[10] = '{0,1,1,0,0,0,32'h0,        2'b10,0,0,0,0,0,32'h0};
    tbl[11] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[12] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[13] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[14] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,1,0,0,32'h0};
    tbl[15] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[16] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[17] = '{0,1,1,0,0,0,32'h0,        2'b01,0,0,0,1,1,32'h0};
    tbl[18] = '{0,1,1,0,0,1,32'hCAFEF00D, 2'b01,1,0,0,1,1,32'hCAFEF00D};
    tbl[19] = '{0,0,0,0,0,0,32'h0,        2'b01,0,0,0,0,0,32'h0};
    tbl[20] = '{0,0,0,1,1,0,32'h0,        2'b00,0,0,0,0,0,32'h0};
    tbl[21] = '{0,0,0,1,1,0,32'h0,        2'b10,0,0,0,1,1,32'h0};
    tbl[22] = '{1,0,0,1,1,1,32'h55AA55AA, 2'b10,0,0,0,0,0,32'h0};
    tbl[23] = '{0,0,0,1,1,1,32'h55AA55AA, 2'b00,0,0,0,0,0,32'h0};
    tbl[24] = '{0,0,0,1,1,0,32'h0,        2'b10,0,0,0,1,1,32'h0};
    tbl[25] = '{0,0,0,0,0,0,32'h0,        2'b10,0,0,0,0,0,32'h0};
    tbl[26] = '{0,0,0,0,0,0,32'h0,        2'b00,0,0,0,0,0,32'h0};

    for (int i = 0; i < 3; i++) begin
      own[i] = -1;
      lst[i] = 1;
      cnt[i] = 0;
    end
    rst = 1'b1;
    we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h0000_1000; wdat[0] = 32'h0;
    we[1] = 1'b1; sel[1] = 4'h3; adr[1] = 32'h0000_2000; wdat[1] = 32'hAAAA_0001;
    cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    set_all_ack(1'b0, 32'h0);

    for (int k = 0; k < 27; k++) begin
      rst = tbl[k].r;
      cyc[0] = tbl[k].c0; stb[0] = tbl[k].s0;
      cyc[1] = tbl[k].c1; stb[1] = tbl[k].s1;
      set_all_ack(tbl[k].a, tbl[k].d);
      settle();
      chk($sformatf("vec%0d", k),
          141'({o_gnt[0], o_m0ack[0], o_m1ack[0], o_m0err[0], o_scyc[0], o_sstb[0], o_m0dat[0]}),
          141'({tbl[k].g, tbl[k].k0, tbl[k].k1, tbl[k].e0, tbl[k].sc, tbl[k].ss, tbl[k].q0}));
      adv();
    end

    // Both masters raise cyc together three times: fixed priority always picks m0,
    // round-robin alternates starting from m0.
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
    rst = 1'b1; cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0; set_all_ack(1'b0, 32'h0);
    settle(); adv();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; set_all_ack(1'b0, 32'h0);
      settle();
      chk($sformatf("rr_idle%0d", r), 141'(o_gnt[0]), 141'(2'b00));
      adv();
      set_all_ack(1'b1, 32'h0BAD_0000 + r);
      settle();
      chk($sformatf("fixed_gnt%0d", r), 141'(o_gnt[0]), 141'(2'b01));
      chk($sformatf("rr_gnt%0d", r), 141'(o_gnt[1]), 141'(rr_exp[r]));
      chk($sformatf("fixed_ack%0d", r), 141'({o_m0ack[0], o_m1ack[0]}), 141'(2'b10));
      adv();
      cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0; set_all_ack(1'b0, 32'h0);
      settle(); adv();
    end

    // A hung slave: watchdog instance pulses err repeatedly, disabled one never does.
    rst = 1'b1; settle(); adv();
    rst = 1'b0;
    cyc[0] = 1; stb[0] = 1;
    errs0 = 0; errs2 = 0;
    for (int c = 0; c < 1000; c++) begin
      settle();
      if (o_m0err[0]) errs0++;
      if (o_m0err[2]) errs2++;
      adv();
    end
    chk("nowdog_errs", 141'(errs2), 141'(0));
    chk("wdog_errs_seen", 141'(errs0 >= 200), 141'(1));
    chk("nowdog_gnt_held", 141'(o_gnt[2]), 141'(2'b01));
    cyc[0] = 0; stb[0] = 0;
    settle(); adv();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(149) == 0);
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) cyc[m] = ($urandom_range(7) != 0);
        else        cyc[m] = ($urandom_range(2) == 0);
        stb[m]  = cyc[m] && ($urandom_range(3) != 0);
        we[m]   = 1'($urandom_range(1));
        sel[m]  = 4'($urandom_range(15));
        adr[m]  = $urandom;
        wdat[m] = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        ack[i]  = ($urandom_range(3) == 0);
        sdat[i] = $urandom;
      end
      settle();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
